rggen_indirect_access_initiator: RTL

Bus-side initiator for indirect registers. It accepts one request at a time carrying an index, a direction and data. For each request it issues a write to the index register, then a read or write to the shared data register, on the rggen register-bus interface that indirect responder registers consume. It caches the last index written, so repeated accesses to the same index skip the index phase, and it returns a single status and read-data response per request.

---
 rtl/rggen_indirect_access_initiator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rggen_indirect_access_initiator.sv
// Indirect register initiator: writes the index register (skipped when the cached index matches),
// then accesses the shared data register; one request in flight, all outputs registered.
module rggen_indirect_access_initiator #(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter int                       BUS_WIDTH     = 32,
  parameter int                       INDEX_WIDTH   = 8,
  parameter logic [ADDRESS_WIDTH-1:0] INDEX_ADDRESS = '0,
  parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS  = ADDRESS_WIDTH'(4)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_request_valid,
  output logic                     o_request_ready,
  input  logic                     i_request_write,
  input  logic [INDEX_WIDTH-1:0]   i_request_index,
  input  logic [BUS_WIDTH-1:0]     i_request_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_request_strobe,
  output logic                     o_response_valid,
  input  logic                     i_response_ready,
  output logic [1:0]               o_response_status,
  output logic [BUS_WIDTH-1:0]     o_response_read_data,
  output logic                     o_register_valid,
  output logic [1:0]               o_register_access,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_register_strobe,
  input  logic                     i_register_ready,
  input  logic [1:0]               i_register_status,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);
  localparam int         STRB_WIDTH   = BUS_WIDTH / 8;
  localparam int         INDEX_BYTES  = (INDEX_WIDTH + 7) / 8;
  localparam logic [1:0] ACCESS_READ  = 2'b10;
  localparam logic [1:0] ACCESS_WRITE = 2'b11;

  typedef enum logic [1:0] {IDLE, INDEX, DATA, RESPONSE} state_e;

  state_e                   state_q, state_d;
  logic                     write_q, write_d;
  logic [INDEX_WIDTH-1:0]   index_q, index_d;
  logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]    strobe_q, strobe_d;
  logic                     cache_valid_q, cache_valid_d;
  logic [INDEX_WIDTH-1:0]   cache_index_q, cache_index_d;
  logic                     reg_valid_q, reg_valid_d;
  logic [1:0]               reg_access_q, reg_access_d;
  logic [ADDRESS_WIDTH-1:0] reg_address_q, reg_address_d;
  logic [BUS_WIDTH-1:0]     reg_wdata_q, reg_wdata_d;
  logic [STRB_WIDTH-1:0]    reg_strobe_q, reg_strobe_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [1:0]               rsp_status_q, rsp_status_d;
  logic [BUS_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [STRB_WIDTH-1:0]    index_strobe;

  // Enable every byte lane that carries part of the index.
  always_comb begin
    index_strobe = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      index_strobe[i] = (i < INDEX_BYTES);
    end
  end

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    index_d       = index_q;
    wdata_d       = wdata_q;
    strobe_d      = strobe_q;
    cache_valid_d = cache_valid_q;
    cache_index_d = cache_index_q;
    reg_valid_d   = reg_valid_q;
    reg_access_d  = reg_access_q;
    reg_address_d = reg_address_q;
    reg_wdata_d   = reg_wdata_q;
    reg_strobe_d  = reg_strobe_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_status_d  = rsp_status_q;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_request_valid) begin
          write_d     = i_request_write;
          index_d     = i_request_index;
          wdata_d     = i_request_write_data;
          strobe_d    = i_request_strobe;
          reg_valid_d = 1'b1;
          if (cache_valid_q && (cache_index_q == i_request_index)) begin
            state_d       = DATA;
            reg_access_d  = i_request_write ? ACCESS_WRITE : ACCESS_READ;
            reg_address_d = DATA_ADDRESS;
            reg_wdata_d   = i_request_write ? i_request_write_data : '0;
            reg_strobe_d  = i_request_strobe;
          end else begin
            state_d       = INDEX;
            reg_access_d  = ACCESS_WRITE;
            reg_address_d = INDEX_ADDRESS;
            reg_wdata_d   = BUS_WIDTH'(i_request_index);
            reg_strobe_d  = index_strobe;
          end
        end
      end
      INDEX: begin
        if (i_register_ready) begin
          if (i_register_status[1]) begin
            // The responder may hold a stale index now, so the cache cannot be trusted.
            state_d       = RESPONSE;
            cache_valid_d = 1'b0;
            reg_valid_d   = 1'b0;
            reg_access_d  = '0;
            reg_address_d = '0;
            reg_wdata_d   = '0;
            reg_strobe_d  = '0;
            rsp_valid_d   = 1'b1;
            rsp_status_d  = i_register_status;
            rsp_rdata_d   = '0;
          end else begin
            state_d       = DATA;
            cache_valid_d = 1'b1;
            cache_index_d = index_q;
            reg_access_d  = write_q ? ACCESS_WRITE : ACCESS_READ;
            reg_address_d = DATA_ADDRESS;
            reg_wdata_d   = write_q ? wdata_q : '0;
            reg_strobe_d  = strobe_q;
          end
        end
      end
      DATA: begin
        if (i_register_ready) begin
          state_d       = RESPONSE;
          reg_valid_d   = 1'b0;
          reg_access_d  = '0;
          reg_address_d = '0;
          reg_wdata_d   = '0;
          reg_strobe_d  = '0;
          rsp_valid_d   = 1'b1;
          rsp_status_d  = i_register_status;
          rsp_rdata_d   = (!write_q && !i_register_status[1]) ? i_register_read_data : '0;
        end
      end
      RESPONSE: begin
        if (i_response_ready) begin
          state_d      = IDLE;
          rsp_valid_d  = 1'b0;
          rsp_status_d = '0;
          rsp_rdata_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      index_q       <= '0;
      wdata_q       <= '0;
      strobe_q      <= '0;
      cache_valid_q <= 1'b0;
      cache_index_q <= '0;
      reg_valid_q   <= 1'b0;
      reg_access_q  <= '0;
      reg_address_q <= '0;
      reg_wdata_q   <= '0;
      reg_strobe_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      index_q       <= index_d;
      wdata_q       <= wdata_d;
      strobe_q      <= strobe_d;
      cache_valid_q <= cache_valid_d;
      cache_index_q <= cache_index_d;
      reg_valid_q   <= reg_valid_d;
      reg_access_q  <= reg_access_d;
      reg_address_q <= reg_address_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_strobe_q  <= reg_strobe_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign o_request_ready       = (state_q == IDLE);
  assign o_response_valid      = rsp_valid_q;
  assign o_response_status     = rsp_status_q;
  assign o_response_read_data  = rsp_rdata_q;
  assign o_register_valid      = reg_valid_q;
  assign o_register_access     = reg_access_q;
  assign o_register_address    = reg_address_q;
  assign o_register_write_data = reg_wdata_q;
  assign o_register_strobe     = reg_strobe_q;

endmodule
